mem_arbiter: RTL and testbench

- Sequences the single shared RAM port between the instruction cache miss path (I) and the data cache path (D).
- Sits between the caches' cache-control interface and the RAM model.
- Default policy is fixed priority to D. A starvation counter forces an I grant after MAX_DSTREAK consecutive D services while I is waiting.
- Each access is registered-granted, then held until RAM signals completion.

---
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter for the single shared RAM port between the instruction-miss (I) and data (D) cache paths.
// D has fixed priority; a streak counter forces an I grant after MAX_DSTREAK back-to-back D services.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ramready
);

  localparam int STREAK_W = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t              state;
  state_t              nextState;
  logic [STREAK_W-1:0] dstreak;
  logic [STREAK_W-1:0] nextDstreak;

  logic dReq;
  logic forceI;

  assign dReq   = dREN | dWEN;
  assign forceI = (dstreak == STREAK_MAX);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      dstreak <= '0;
    end else begin
      state   <= nextState;
      dstreak <= nextDstreak;
    end
  end

  // Completion wins over a dropped request in the same cycle; a drop without ramready is an abort.
  always_comb begin
    nextState   = state;
    nextDstreak = dstreak;
    case (state)
      IDLE: begin
        if (iREN && (forceI || !dReq)) begin
          nextState = SERVE_I;
        end else if (dReq) begin
          nextState = SERVE_D;
        end
      end
      SERVE_I: begin
        if (ramready) begin
          nextState   = IDLE;
          nextDstreak = '0;
        end else if (!iREN) begin
          nextState = IDLE;
        end
      end
      SERVE_D: begin
        if (ramready) begin
          nextState = IDLE;
          if (!iREN) begin
            nextDstreak = '0;
          end else if (dstreak != STREAK_MAX) begin
            nextDstreak = dstreak + STREAK_W'(1);
          end
        end else if (!dReq) begin
          nextState = IDLE;
        end
      end
      default: begin
        nextState   = IDLE;
        nextDstreak = '0;
      end
    endcase
  end

  // RAM side is a pure function of the granted owner so enables follow the requester without delay.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (state)
      SERVE_I: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        iwait   = ~ramready;
      end
      SERVE_D: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = ~ramready;
      end
      default: begin
        ramREN = 1'b0;
      end
    endcase
  end

  assign iload = ramload;
  assign dload = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed checks of mem_arbiter against a grant-owner/streak reference model.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MAXD   = 4;

  logic              CLK = 1'b0;
  logic              nRST;
  logic              iREN, dREN, dWEN, ramready;
  logic [ADDR_W-1:0] iaddr, daddr;
  logic [DATA_W-1:0] dstore, ramload;
  logic              iwait, dwait, ramREN, ramWEN;
  logic [DATA_W-1:0] iload, dload, ramstore;
  logic [ADDR_W-1:0] ramaddr;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: who owns the RAM port (0 none, 1 I, 2 D) and the D streak length.
  int mOwner  = 0;
  int mStreak = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DSTREAK(MAXD)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic expRamREN();
    if (mOwner == 1) return 1'b1;
    if (mOwner == 2) return dREN & ~dWEN;
    return 1'b0;
  endfunction
  function automatic logic expRamWEN();
    return (mOwner == 2) ? dWEN : 1'b0;
  endfunction
  function automatic logic [ADDR_W-1:0] expAddr();
    if (mOwner == 1) return iaddr;
    if (mOwner == 2) return daddr;
    return '0;
  endfunction
  function automatic logic [DATA_W-1:0] expStore();
    return (mOwner == 2) ? dstore : '0;
  endfunction
  function automatic logic expIwait();
    return !((mOwner == 1) && ramready);
  endfunction
  function automatic logic expDwait();
    return !((mOwner == 2) && ramready);
  endfunction

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic tick();
    int nOwner, nStreak;
    nOwner  = mOwner;
    nStreak = mStreak;
    if (mOwner == 0) begin
      if (iREN && (mStreak == MAXD || !(dREN || dWEN))) nOwner = 1;
      else if (dREN || dWEN) nOwner = 2;
    end else if (mOwner == 1) begin
      if (ramready) begin nOwner = 0; nStreak = 0; end
      else if (!iREN) nOwner = 0;
    end else begin
      if (ramready) begin
        nOwner  = 0;
        nStreak = iREN ? ((mStreak < MAXD) ? mStreak + 1 : MAXD) : 0;
      end else if (!dREN && !dWEN) nOwner = 0;
    end
    @(posedge CLK);
    mOwner  = nOwner;
    mStreak = nStreak;
    #1;
  endtask

  task automatic clearInputs();
    iREN = 0; dREN = 0; dWEN = 0; ramready = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
  endtask

  task automatic test_reset();
    clearInputs();
    nRST = 0; iREN = 1; dREN = 1;
    iaddr = 32'h0000_0010; daddr = 32'h0000_0020; dstore = 32'h1234_5678;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    vectors++; if (ramREN !== 1'b0) begin miscompares++; $display("FAIL reset_ramREN got=%b exp=0", ramREN); end
    vectors++; if (ramWEN !== 1'b0) begin miscompares++; $display("FAIL reset_ramWEN got=%b exp=0", ramWEN); end
    vectors++; if (ramaddr !== '0) begin miscompares++; $display("FAIL reset_ramaddr got=%h exp=0", ramaddr); end
    vectors++; if (ramstore !== '0) begin miscompares++; $display("FAIL reset_ramstore got=%h exp=0", ramstore); end
    vectors++; if ({iwait, dwait} !== 2'b11) begin miscompares++; $display("FAIL reset_waits got=%b exp=11", {iwait, dwait}); end
    nRST = 1;
    mOwner = 0; mStreak = 0;
    tick();
    @(negedge CLK);
    vectors++; if (ramREN !== 1'b1 || ramaddr !== 32'h20) begin
      miscompares++; $display("FAIL reset_release_dprio got ramREN=%b addr=%h exp ramREN=1 addr=00000020", ramREN, ramaddr); end
    vectors++; if ({iwait, dwait} !== 2'b11) begin miscompares++; $display("FAIL reset_release_waits got=%b exp=11", {iwait, dwait}); end
    clearInputs();
    tick();
    @(negedge CLK);
    vectors++; if (ramREN !== 1'b0) begin miscompares++; $display("FAIL reset_dabort_ramREN got=%b exp=0", ramREN); end
  endtask

  task automatic test_i_read();
    clearInputs();
    iREN = 1; iaddr = 32'h40;
    tick();
    @(negedge CLK);
    vectors++; if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40) begin
      miscompares++; $display("FAIL iread_grant got REN=%b WEN=%b addr=%h exp 1 0 00000040", ramREN, ramWEN, ramaddr); end
    vectors++; if (iwait !== 1'b1) begin miscompares++; $display("FAIL iread_wait_early got=%b exp=1", iwait); end
    tick();
    ramready = 1; ramload = 32'h8C22_0004;
    @(negedge CLK);
    vectors++; if (iwait !== 1'b0 || dwait !== 1'b1) begin
      miscompares++; $display("FAIL iread_done got iwait=%b dwait=%b exp 0 1", iwait, dwait); end
    vectors++; if (iload !== 32'h8C22_0004) begin miscompares++; $display("FAIL iread_iload got=%h exp=8c220004", iload); end
    tick();
    ramready = 0;
    @(negedge CLK);
    vectors++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin
      miscompares++; $display("FAIL iread_turnaround got REN=%b iwait=%b exp 0 1", ramREN, iwait); end
    tick();
    @(negedge CLK);
    vectors++; if (ramREN !== 1'b1) begin miscompares++; $display("FAIL iread_regrant got=%b exp=1", ramREN); end
    iREN = 0;
    tick();
  endtask

  task automatic test_d_write();
    for (int pass = 0; pass < 2; pass++) begin
      clearInputs();
      dWEN = 1; dREN = (pass == 1); daddr = 32'h100; dstore = 32'hDEAD_BEEF;
      tick();
      @(negedge CLK);
      vectors++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin
        miscompares++; $display("FAIL dwrite_en pass=%0d got WEN=%b REN=%b exp 1 0", pass, ramWEN, ramREN); end
      vectors++; if (ramstore !== 32'hDEAD_BEEF || ramaddr !== 32'h100) begin
        miscompares++; $display("FAIL dwrite_bus pass=%0d got store=%h addr=%h exp deadbeef 00000100", pass, ramstore, ramaddr); end
      vectors++; if (dwait !== 1'b1) begin miscompares++; $display("FAIL dwrite_wait_early pass=%0d got=%b exp=1", pass, dwait); end
      tick();
      ramready = 1;
      @(negedge CLK);
      vectors++; if (dwait !== 1'b0 || iwait !== 1'b1) begin
        miscompares++; $display("FAIL dwrite_done pass=%0d got dwait=%b iwait=%b exp 0 1", pass, dwait, iwait); end
      tick();
      clearInputs();
      @(negedge CLK);
      vectors++; if (ramWEN !== 1'b0 || dwait !== 1'b1) begin
        miscompares++; $display("FAIL dwrite_idle pass=%0d got WEN=%b dwait=%b exp 0 1", pass, ramWEN, dwait); end
    end
  endtask

  task automatic test_starvation();
    string got, want;
    clearInputs();
    @(negedge CLK);
    nRST = 0; #1; nRST = 1;
    mOwner = 0; mStreak = 0;
    @(posedge CLK); #1;
    iREN = 1; dREN = 1; ramready = 1; iaddr = 32'h44; daddr = 32'h200;
    got = ""; want = "DDDDIDDDDI";
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (!dwait) got = {got, "D"};
      if (!iwait) begin
        got = {got, "I"};
        vectors++; if (ramaddr !== 32'h44) begin miscompares++; $display("FAIL starve_iaddr got=%h exp=00000044", ramaddr); end
      end
      tick();
    end
    vectors++; if (got != want) begin miscompares++; $display("FAIL starve_order got=%s exp=%s", got, want); end
    clearInputs();
    tick();
  endtask

  task automatic test_abort();
    clearInputs();
    iREN = 1; iaddr = 32'h80;
    tick();
    @(negedge CLK);
    vectors++; if (ramREN !== 1'b1) begin miscompares++; $display("FAIL abort_igrant got=%b exp=1", ramREN); end
    iREN = 0;
    @(negedge CLK);
    vectors++; if (iwait !== 1'b1) begin miscompares++; $display("FAIL abort_nowait got=%b exp=1", iwait); end
    tick();
    @(negedge CLK);
    vectors++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin
      miscompares++; $display("FAIL abort_idle got REN=%b iwait=%b exp 0 1", ramREN, iwait); end
    dWEN = 1; daddr = 32'h300; dstore = 32'hCAFE_F00D;
    tick();
    @(negedge CLK);
    vectors++; if (ramWEN !== 1'b1) begin miscompares++; $display("FAIL abort_dgrant got=%b exp=1", ramWEN); end
    ramready = 1;
    nRST = 0;
    #1;
    vectors++; if (dwait !== 1'b1 || ramWEN !== 1'b0) begin
      miscompares++; $display("FAIL abort_reset got dwait=%b WEN=%b exp 1 0", dwait, ramWEN); end
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1;
    mOwner = 0; mStreak = 0;
    clearInputs();
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 10000; c++) begin
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
      if (mOwner == 0) begin
        iREN = $urandom_range(0, 1); dREN = $urandom_range(0, 1); dWEN = $urandom_range(0, 1);
        ramready = $urandom_range(0, 1);
      end else if (mOwner == 1) begin
        iREN = ($urandom_range(0, 9) != 0);
        ramready = iREN ? ($urandom_range(0, 9) < 4) : 1'b0;
        dREN = $urandom_range(0, 1); dWEN = $urandom_range(0, 1);
      end else begin
        iREN = $urandom_range(0, 1);
        if ($urandom_range(0, 9) != 0) begin
          {dREN, dWEN} = 2'($urandom_range(1, 3));
          ramready = ($urandom_range(0, 9) < 4);
        end else begin
          dREN = 0; dWEN = 0; ramready = 0;
        end
      end
      @(negedge CLK);
      vectors++; if (!(mOwner == 1 && !iREN) && ramREN !== expRamREN()) begin
        miscompares++; $display("FAIL rand_ramREN cyc=%0d got=%b exp=%b", c, ramREN, expRamREN()); end
      vectors++; if (ramWEN !== expRamWEN()) begin
        miscompares++; $display("FAIL rand_ramWEN cyc=%0d got=%b exp=%b", c, ramWEN, expRamWEN()); end
      vectors++; if (ramaddr !== expAddr() || ramstore !== expStore()) begin
        miscompares++; $display("FAIL rand_bus cyc=%0d got addr=%h store=%h exp %h %h", c, ramaddr, ramstore, expAddr(), expStore()); end
      vectors++; if (iwait !== expIwait() || dwait !== expDwait()) begin
        miscompares++; $display("FAIL rand_waits cyc=%0d got i=%b d=%b exp %b %b", c, iwait, dwait, expIwait(), expDwait()); end
      vectors++; if (iload !== ramload || dload !== ramload) begin
        miscompares++; $display("FAIL rand_load cyc=%0d got i=%h d=%h exp %h", c, iload, dload, ramload); end
      vectors++; if ((!iwait && !dwait) || (ramREN && ramWEN)) begin
        miscompares++; $display("FAIL rand_exclusive cyc=%0d got iwait=%b dwait=%b REN=%b WEN=%b", c, iwait, dwait, ramREN, ramWEN); end
      tick();
    end
    clearInputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_starvation();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
